axi4_mem_ctrl: RTL

- AXI4 slave front-end that converts AXI4 burst transactions into single-port word accesses on the on-chip memory's `mem_en`/`mem_we`/`mem_addr`/`mem_wdata`/`mem_rdata` interface.
- Sits directly upstream of the memory, which has a 1-cycle read latency.
- Handles one transaction at a time, with round-robin arbitration between the read and write address channels.
- Supports FIXED and INCR bursts, with SLVERR reporting for illegal requests.

---
 rtl/axi4_mem_ctrl.sv | 182 ++++++++++++++++++
 1 files changed

// File: rtl/axi4_mem_ctrl.sv
// AXI4 slave front-end for a single-port on-chip memory with 1-cycle read
// latency. One burst at a time, round-robin between AW and AR, FIXED/INCR
// bursts, SLVERR for illegal requests and bad write beats.
module axi4_mem_ctrl #(
  parameter int DATA_WIDTH     = 32,
  parameter int ADDR_WIDTH     = 10,
  parameter int DEPTH          = 1024,
  parameter int AXI_ADDR_WIDTH = 16,
  parameter int ID_WIDTH       = 4
) (
  input  logic                      clk,
  input  logic                      rst,
  input  logic [ID_WIDTH-1:0]       awid,
  input  logic [AXI_ADDR_WIDTH-1:0] awaddr,
  input  logic [7:0]                awlen,
  input  logic [2:0]                awsize,
  input  logic [1:0]                awburst,
  input  logic                      awvalid,
  output logic                      awready,
  input  logic [DATA_WIDTH-1:0]     wdata,
  input  logic [DATA_WIDTH/8-1:0]   wstrb,
  input  logic                      wlast,
  input  logic                      wvalid,
  output logic                      wready,
  output logic [ID_WIDTH-1:0]       bid,
  output logic [1:0]                bresp,
  output logic                      bvalid,
  input  logic                      bready,
  input  logic [ID_WIDTH-1:0]       arid,
  input  logic [AXI_ADDR_WIDTH-1:0] araddr,
  input  logic [7:0]                arlen,
  input  logic [2:0]                arsize,
  input  logic [1:0]                arburst,
  input  logic                      arvalid,
  output logic                      arready,
  output logic [ID_WIDTH-1:0]       rid,
  output logic [DATA_WIDTH-1:0]     rdata,
  output logic [1:0]                rresp,
  output logic                      rlast,
  output logic                      rvalid,
  input  logic                      rready,
  output logic                      mem_en,
  output logic                      mem_we,
  output logic [ADDR_WIDTH-1:0]     mem_addr,
  output logic [DATA_WIDTH-1:0]     mem_wdata,
  input  logic [DATA_WIDTH-1:0]     mem_rdata
);

  localparam logic [1:0] BURST_FIXED = 2'b00;
  localparam logic [1:0] BURST_INCR  = 2'b01;
  localparam logic [1:0] RESP_OKAY   = 2'b00;
  localparam logic [1:0] RESP_SLVERR = 2'b10;

  typedef enum logic [2:0] {IDLE, WR_DATA, WR_RESP, RD_ISSUE, RD_DATA} state_t;

  state_t                  state_q;
  logic                    wr_prio_q;
  logic [ID_WIDTH-1:0]     id_q;
  logic [ADDR_WIDTH-1:0]   word_q;
  logic [7:0]              len_q;
  logic [7:0]              cnt_q;
  logic                    fixed_q;
  logic                    req_err_q;   // request itself illegal: suppress all accesses
  logic                    err_q;       // sticky burst error reported in bresp
  logic                    rd_first_q;  // first RD_DATA cycle: memory output is live
  logic [DATA_WIDTH-1:0]   rdata_q;

  logic w_fire;
  logic strb_full;
  logic is_last;
  logic wr_ok;

  // Illegal request: wrong size, WRAP/reserved burst, misaligned, out of range.
  function automatic logic req_err(input logic [AXI_ADDR_WIDTH-1:0] addr,
                                   input logic [7:0] len,
                                   input logic [2:0] size,
                                   input logic [1:0] burst);
    logic [31:0] last_word;
    last_word = 32'(addr[ADDR_WIDTH+1:2]) + 32'(len);
    req_err = (size != 3'd2) ||
              (burst != BURST_FIXED && burst != BURST_INCR) ||
              (addr[1:0] != 2'b00) ||
              ((addr >> (ADDR_WIDTH + 2)) != '0) ||
              (burst == BURST_INCR && last_word > 32'(DEPTH - 1));
  endfunction

  assign awready   = (state_q == IDLE) && awvalid && (!arvalid || wr_prio_q);
  assign arready   = (state_q == IDLE) && arvalid && (!awvalid || !wr_prio_q);
  assign wready    = (state_q == WR_DATA);
  assign w_fire    = wvalid && wready;
  assign strb_full = &wstrb;
  assign is_last   = (cnt_q == len_q);
  assign wr_ok     = w_fire && !req_err_q && strb_full;

  assign mem_en    = wr_ok || ((state_q == RD_ISSUE) && !req_err_q);
  assign mem_we    = wr_ok;
  assign mem_addr  = word_q;
  assign mem_wdata = wdata;

  assign bvalid = (state_q == WR_RESP);
  assign bid    = id_q;
  assign bresp  = err_q ? RESP_SLVERR : RESP_OKAY;

  assign rvalid = (state_q == RD_DATA);
  assign rid    = id_q;
  assign rdata  = req_err_q ? '0 : (rd_first_q ? mem_rdata : rdata_q);
  assign rresp  = req_err_q ? RESP_SLVERR : RESP_OKAY;
  assign rlast  = is_last;

  // Transaction FSM: arbitration, request latching, beat counting.
  always_ff @(posedge clk) begin
    if (rst) begin
      state_q    <= IDLE;
      wr_prio_q  <= 1'b1;
      cnt_q      <= '0;
      err_q      <= 1'b0;
      rd_first_q <= 1'b0;
    end else begin
      rd_first_q <= (state_q == RD_ISSUE);
      case (state_q)
        IDLE: begin
          if (awvalid && awready) begin
            id_q      <= awid;
            word_q    <= awaddr[ADDR_WIDTH+1:2];
            len_q     <= awlen;
            fixed_q   <= (awburst == BURST_FIXED);
            req_err_q <= req_err(awaddr, awlen, awsize, awburst);
            err_q     <= req_err(awaddr, awlen, awsize, awburst);
            cnt_q     <= '0;
            wr_prio_q <= 1'b0;
            state_q   <= WR_DATA;
          end else if (arvalid && arready) begin
            id_q      <= arid;
            word_q    <= araddr[ADDR_WIDTH+1:2];
            len_q     <= arlen;
            fixed_q   <= (arburst == BURST_FIXED);
            req_err_q <= req_err(araddr, arlen, arsize, arburst);
            err_q     <= req_err(araddr, arlen, arsize, arburst);
            cnt_q     <= '0;
            wr_prio_q <= 1'b1;
            state_q   <= RD_ISSUE;
          end
        end
        WR_DATA: begin
          if (w_fire) begin
            if (!strb_full || (wlast != is_last)) err_q <= 1'b1;
            if (is_last) begin
              state_q <= WR_RESP;
            end else begin
              cnt_q <= cnt_q + 8'd1;
              if (!fixed_q) word_q <= word_q + ADDR_WIDTH'(1);
            end
          end
        end
        WR_RESP: begin
          if (bready) state_q <= IDLE;
        end
        RD_ISSUE: begin
          state_q <= RD_DATA;
        end
        RD_DATA: begin
          if (rready) begin
            if (is_last) begin
              state_q <= IDLE;
            end else begin
              cnt_q   <= cnt_q + 8'd1;
              if (!fixed_q) word_q <= word_q + ADDR_WIDTH'(1);
              state_q <= RD_ISSUE;
            end
          end
        end
        default: state_q <= IDLE;
      endcase
    end
  end

  // Hold the read word so rdata stays stable while rready is low.
  always_ff @(posedge clk) begin
    if (rd_first_q) rdata_q <= mem_rdata;
  end

endmodule
